// File: rtl/tm1638_button_filter.sv
// Filters the TM1638 key scan for the pong logic: debounces each key across scans,
// emits press/release/auto-repeat pulses and force-releases all keys when scans stop.
module tm1638_button_filter #(
  parameter int         DEBOUNCE_SAMPLES = 3,
  parameter int         REPEAT_DELAY     = 12000000,
  parameter int         REPEAT_PERIOD    = 3000000,
  parameter logic [7:0] REPEAT_MASK      = 8'hFF,
  parameter int         SCAN_TIMEOUT     = 2400000
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       SAMPLE_VALID,
  input  logic [7:0] BUTTONS_IN,
  output logic [7:0] BUTTONS_STABLE,
  output logic [7:0] PRESS_PULSE,
  output logic [7:0] RELEASE_PULSE,
  output logic [7:0] REPEAT_PULSE,
  output logic       STALE
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
  localparam int WD_W     = $clog2(SCAN_TIMEOUT) + 1;

  localparam logic [3:0]        DEB_LAST    = 4'(DEBOUNCE_SAMPLES);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(SCAN_TIMEOUT - 1);
  localparam logic [WD_W-1:0]   WD_ONE      = WD_W'(1);

  logic [7:0]        r_stable;
  logic [7:0]        r_press;
  logic [7:0]        r_release;
  logic [7:0]        r_repeat;
  logic [7:0]        r_phase;
  logic [3:0]        r_agree [8];
  logic [HOLD_W-1:0] r_hold  [8];
  logic [WD_W-1:0]   r_wd;
  logic              r_stale;
  logic              r_stale_d;

  logic              w_force;
  logic [7:0]        w_stable_nxt;
  logic [7:0]        w_press_nxt;
  logic [7:0]        w_release_nxt;
  logic [7:0]        w_repeat_nxt;
  logic [7:0]        w_phase_nxt;
  logic [3:0]        w_agree_nxt [8];
  logic [HOLD_W-1:0] w_hold_nxt  [8];

  // NOTE: every signal gets a default at the top of the block so no path can
  // leave it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    // Force release fires only in the first cycle STALE is visible.
    w_force = r_stale & ~r_stale_d;
    for (int i = 0; i < 8; i++) begin
      w_stable_nxt[i]  = r_stable[i];
      w_press_nxt[i]   = 1'b0;
      w_release_nxt[i] = 1'b0;
      w_repeat_nxt[i]  = 1'b0;
      w_phase_nxt[i]   = r_phase[i];
      w_agree_nxt[i]   = r_agree[i];
      w_hold_nxt[i]    = r_hold[i];

      // A sample landing in the force cycle is dropped; the key restarts from released.
      if (w_force) begin
        w_stable_nxt[i]  = 1'b0;
        w_release_nxt[i] = r_stable[i];
        w_agree_nxt[i]   = 4'd0;
      end else if (SAMPLE_VALID) begin
        if (BUTTONS_IN[i] == r_stable[i]) begin
          w_agree_nxt[i] = 4'd0;
        end else if ((r_agree[i] + 4'd1) == DEB_LAST) begin
          w_stable_nxt[i]  = ~r_stable[i];
          w_press_nxt[i]   = ~r_stable[i];
          w_release_nxt[i] = r_stable[i];
          w_agree_nxt[i]   = 4'd0;
        end else begin
          w_agree_nxt[i] = r_agree[i] + 4'd1;
        end
      end

      // Releasing on the threshold cycle lands in the first branch, so no repeat.
      if (!w_stable_nxt[i] || !REPEAT_MASK[i]) begin
        w_hold_nxt[i]  = '0;
        w_phase_nxt[i] = 1'b0;
      end else if (!r_stable[i]) begin
        w_hold_nxt[i]  = HOLD_ONE;
        w_phase_nxt[i] = 1'b0;
      end else if (r_hold[i] == (r_phase[i] ? HOLD_PERIOD : HOLD_DELAY)) begin
        w_repeat_nxt[i] = 1'b1;
        w_hold_nxt[i]   = HOLD_ONE;
        w_phase_nxt[i]  = 1'b1;
      end else if (r_hold[i] != '1) begin
        w_hold_nxt[i] = r_hold[i] + HOLD_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      r_phase   <= '0;
      r_wd      <= '0;
      r_stale   <= 1'b0;
      r_stale_d <= 1'b0;
      // NOTE: the counter arrays are real flops, not RAM, so they take the async
      // reset like everything else; a stale count must not survive reset.
      for (int i = 0; i < 8; i++) begin
        r_agree[i] <= '0;
        r_hold[i]  <= '0;
      end
    end else begin
      r_stable  <= w_stable_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_repeat  <= w_repeat_nxt;
      r_phase   <= w_phase_nxt;
      r_stale_d <= r_stale;
      for (int i = 0; i < 8; i++) begin
        r_agree[i] <= w_agree_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
      end

      if (SAMPLE_VALID) begin
        r_wd    <= '0;
        r_stale <= 1'b0;
      end else begin
        if (r_wd != '1) begin
          r_wd <= r_wd + WD_ONE;
        end
        // This cycle completes SCAN_TIMEOUT consecutive cycles without a scan.
        if (r_wd >= WD_LAST) begin
          r_stale <= 1'b1;
        end
      end
    end
  end

  assign BUTTONS_STABLE = r_stable;
  assign PRESS_PULSE    = r_press;
  assign RELEASE_PULSE  = r_release;
  assign REPEAT_PULSE   = r_repeat;
  assign STALE          = r_stale;

endmodule

// File: tb/tb_tm1638_button_filter.sv
// Directed bench for tm1638_button_filter: a cycle-indexed behavioural model is
// compared every cycle, plus literal expectations at the key points of each scenario.
module tb_tm1638_button_filter;

  localparam int         DS    = 3;
  localparam int         RD    = 20;
  localparam int         RP    = 8;
  localparam int         TOUT  = 100;
  localparam logic [7:0] MASK  = 8'h0F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] buttons_in = 8'h00;
  logic [7:0] buttons_stable;
  logic [7:0] press_pulse;
  logic [7:0] release_pulse;
  logic [7:0] repeat_pulse;
  logic       stale;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b1;

  tm1638_button_filter #(
    .DEBOUNCE_SAMPLES(DS),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK),
    .SCAN_TIMEOUT    (TOUT)
  ) dut (
    .CLK_IN        (clk),
    .RST_IN        (rst_n),
    .SAMPLE_VALID  (sample_valid),
    .BUTTONS_IN    (buttons_in),
    .BUTTONS_STABLE(buttons_stable),
    .PRESS_PULSE   (press_pulse),
    .RELEASE_PULSE (release_pulse),
    .REPEAT_PULSE  (repeat_pulse),
    .STALE         (stale)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycle index of each press, count of consecutive disagreeing samples,
  // count of consecutive scan-less cycles. Repeats are due at press + RD + n*RP.
  logic [7:0] exp_stable  = '0;
  logic [7:0] exp_press   = '0;
  logic [7:0] exp_release = '0;
  logic [7:0] exp_repeat  = '0;
  logic       exp_stale   = 1'b0;
  logic [7:0] prev_stable = '0;
  int         run [8];
  int         press_at [8];
  int         cyc  = 0;
  int         idle = 0;
  bit         force_rel;
  int         held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_stable = '0; exp_press = '0; exp_release = '0; exp_repeat = '0;
      exp_stale = 1'b0; cyc = 0; idle = 0;
      for (int i = 0; i < 8; i++) begin run[i] = 0; press_at[i] = 0; end
    end else begin
      force_rel   = exp_stale && (idle == TOUT);
      prev_stable = exp_stable;
      cyc++;
      exp_press = '0; exp_release = '0; exp_repeat = '0;
      if (force_rel) begin
        exp_release = exp_stable;
        exp_stable  = '0;
        for (int i = 0; i < 8; i++) run[i] = 0;
      end else if (sample_valid) begin
        for (int i = 0; i < 8; i++) begin
          if (buttons_in[i] == exp_stable[i]) run[i] = 0;
          else begin
            run[i]++;
            if (run[i] == DS) begin
              run[i] = 0;
              if (exp_stable[i]) exp_release[i] = 1'b1; else exp_press[i] = 1'b1;
              exp_stable[i] = ~exp_stable[i];
            end
          end
        end
      end
      if (sample_valid) begin idle = 0; exp_stale = 1'b0; end
      else begin idle++; exp_stale = (idle >= TOUT); end
      for (int i = 0; i < 8; i++) begin
        if (exp_press[i]) press_at[i] = cyc;
        else if (exp_stable[i] && prev_stable[i] && MASK[i]) begin
          held = cyc - press_at[i];
          if (held >= RD && ((held - RD) % RP) == 0) exp_repeat[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle_model",
            {31'd0, buttons_stable, press_pulse, release_pulse, repeat_pulse, stale},
            {31'd0, exp_stable, exp_press, exp_release, exp_repeat, exp_stale});
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic [7:0] val);
    buttons_in   = val;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic strobes3(input logic [7:0] val);
    strobe(val); idle_cycles(4);
    strobe(val); idle_cycles(4);
    strobe(val);
  endtask

  int rep_offs[$];
  int cnt;
  int k;
  int off0, off1, off2;

  initial begin
    #1 rst_n = 1'b0;
    idle_cycles(3);
    check("reset_outputs", {buttons_stable, press_pulse, release_pulse, repeat_pulse, stale}, 33'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Clean debounce on key 0, strobes 10 cycles apart.
    strobe(8'h01); idle_cycles(9);
    strobe(8'h01); idle_cycles(9);
    strobe(8'h01);
    check("clean_press", press_pulse, 8'h01);
    check("clean_stable", buttons_stable, 8'h01);
    idle_cycles(1);
    check("clean_press_one_cycle", press_pulse, 8'h00);
    idle_cycles(8);
    strobe(8'h00); idle_cycles(9);
    strobe(8'h00); idle_cycles(9);
    strobe(8'h00);
    check("clean_release", {press_pulse, release_pulse}, 16'h0001);
    idle_cycles(4);

    // Bounce on key 2.
    strobe(8'h04); idle_cycles(4);
    strobe(8'h04); idle_cycles(4);
    strobe(8'h00); idle_cycles(4);
    strobe(8'h04); idle_cycles(4);
    strobe(8'h04);
    check("bounce_no_press", {buttons_stable, press_pulse}, 16'h0000);
    idle_cycles(4);
    strobe(8'h04);
    check("bounce_press", press_pulse, 8'h04);
    idle_cycles(4);
    strobe(8'h00);
    check("glitch_no_release", release_pulse, 8'h00);
    idle_cycles(4);
    strobe(8'h04);
    check("glitch_still_stable", buttons_stable, 8'h04);
    idle_cycles(4);
    strobes3(8'h00);
    idle_cycles(4);

    // Auto-repeat on key 1; offsets counted from the press-pulse cycle.
    strobes3(8'h02);
    check("repeat_press", press_pulse, 8'h02);
    for (int j = 1; j <= 40; j++) begin
      sample_valid = (j % 5 == 0);
      @(posedge clk); #1;
      if (repeat_pulse[1]) rep_offs.push_back(j);
    end
    sample_valid = 1'b0;
    off0 = (rep_offs.size() > 0) ? rep_offs[0] : -1;
    off1 = (rep_offs.size() > 1) ? rep_offs[1] : -1;
    off2 = (rep_offs.size() > 2) ? rep_offs[2] : -1;
    check("repeat_count", rep_offs.size(), 3);
    check("repeat_first_offset", off0, 20);
    check("repeat_second_offset", off1, 28);
    check("repeat_third_offset", off2, 36);
    strobes3(8'h00);
    idle_cycles(4);

    // Masked key 5: press only, no repeat.
    strobes3(8'h20);
    check("masked_press", press_pulse, 8'h20);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      if (repeat_pulse != 8'h00) cnt++;
    end
    check("masked_no_repeat", cnt, 0);
    strobes3(8'h00);
    idle_cycles(4);

    // Simultaneous transitions.
    strobes3(8'hF0);
    idle_cycles(4);
    strobes3(8'h0F);
    check("simultaneous", {press_pulse, release_pulse}, 16'h0FF0);
    idle_cycles(4);
    strobes3(8'h03);
    check("to_03_release", release_pulse, 8'h0C);

    // Watchdog: scans stop with keys 0 and 1 held.
    k = 0;
    while (!stale && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("stale_delay", k, TOUT);
    @(posedge clk); #1;
    check("force_release", {buttons_stable, release_pulse}, 16'h0003);
    @(posedge clk); #1;
    check("force_release_once", {release_pulse, 7'd0, stale}, 16'h0001);
    idle_cycles(5);
    strobe(8'h00);
    check("stale_cleared", stale, 1'b0);
    idle_cycles(4);

    // Asynchronous reset mid-run with key 0 held and repeating.
    strobes3(8'h01);
    idle_cycles(25);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {buttons_stable, press_pulse, release_pulse, repeat_pulse, stale}, 33'd0);
    idle_cycles(2);
    rst_n = 1'b1;
    strobe(8'h01); idle_cycles(4);
    strobe(8'h01);
    check("post_reset_not_yet", buttons_stable, 8'h00);
    idle_cycles(4);
    strobe(8'h01);
    check("post_reset_press", {buttons_stable, press_pulse}, 16'h0101);
    idle_cycles(3);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_button_filter.md
Name: tm1638_button_filter

Overview:
- Sits between the TM1638 driver's button read data and the pong game logic.
- Debounces the 8 raw key bits on scan boundaries and produces per-key stable levels, one-cycle press/release pulses and hold auto-repeat pulses.
- Adds a scan watchdog that forces all keys released if the TM1638 stops delivering scans.
- Runs on the system clock CLK_IN. SAMPLE_VALID is already synchronous to CLK_IN; the upstream sequencer pulses it once per completed button read.

Parameters:
- DEBOUNCE_SAMPLES, 3: consecutive differing scans needed to flip a key's stable state. Range 1..15.
- REPEAT_DELAY, 12000000: CLK_IN cycles from the press pulse to the first repeat pulse. Must be ≥ 2.
- REPEAT_PERIOD, 3000000: CLK_IN cycles between subsequent repeat pulses. Must be ≥ 1.
- REPEAT_MASK, 8'hFF: bit i = 1 enables auto-repeat on key i.
- SCAN_TIMEOUT, 2400000: CLK_IN cycles without SAMPLE_VALID before STALE asserts.

Ports:
- CLK_IN, input, 1: system clock.
- RST_IN, input, 1: reset, asynchronous assert, active-low.
- SAMPLE_VALID, input, 1: one-cycle strobe; BUTTONS_IN is valid in this cycle.
- BUTTONS_IN, input, 8: raw key bits, 1 = pressed.
- BUTTONS_STABLE, output, 8: debounced key levels.
- PRESS_PULSE, output, 8: one-cycle pulse per key on debounced 0→1.
- RELEASE_PULSE, output, 8: one-cycle pulse per key on debounced 1→0.
- REPEAT_PULSE, output, 8: one-cycle auto-repeat pulse while a key is held.
- STALE, output, 1: high while the scan watchdog has expired.

Behaviour:
- Reset: RST_IN low clears, asynchronously, all outputs, all per-key counters and the watchdog counter. All outputs read 0 while RST_IN is low.
- Release: leaving reset is synchronous; the first sample is processed on the first SAMPLE_VALID after release.
- Per-key debounce, applied to key i only in cycles where SAMPLE_VALID = 1:
  - BUTTONS_IN[i] == S[i]: agree counter cleared.
  - Otherwise, if counter+1 == DEBOUNCE_SAMPLES: S[i] toggles and the counter clears.
  - Otherwise the counter increments.
  - Counter width is 4 bits.
  - Cycles without SAMPLE_VALID leave the debounce state unchanged.
- Latency: S[i] and the matching PRESS/RELEASE pulse update on the clock edge that closes the SAMPLE_VALID cycle, so they are visible in the next cycle. Pulses last exactly one cycle. The press and release pulses of a key are mutually exclusive.
- Auto-repeat per key, hold counter of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) + 1:
  - The counter loads 1 in the press-pulse cycle.
  - While S[i] = 1 and REPEAT_MASK[i] = 1, it increments every cycle.
  - When the counter equals REPEAT_DELAY (first repeat) or REPEAT_PERIOD (later repeats), REPEAT_PULSE[i] fires for one cycle and the counter reloads 1.
  - A phase bit selects the delay or period threshold; it is cleared on press.
  - Release, or a masked key, clears the counter and phase, and no repeat pulse fires.
  - Releasing in the same cycle the threshold is hit gives RELEASE_PULSE only.
  - The counter saturates and never wraps.
- Watchdog:
  - The counter clears on SAMPLE_VALID and otherwise increments, saturating.
  - On reaching SCAN_TIMEOUT, STALE goes high and the force-release rule below applies.
  - STALE drops on the next SAMPLE_VALID; that sample is then processed normally.
- Force release on stale:
  - Every key with S = 1 goes to S = 0 with RELEASE_PULSE in the STALE-rising cycle's next cycle.
  - The agree and hold counters clear.
  - Force release happens once per stale episode.
- SAMPLE_VALID held high for consecutive cycles: each cycle counts as a separate sample.
- Keys are fully independent; simultaneous transitions on several keys produce simultaneous pulses.

Test Plan (DEBOUNCE_SAMPLES=3, REPEAT_DELAY=20, REPEAT_PERIOD=8, SCAN_TIMEOUT=100, REPEAT_MASK=8'h0F):
- Reset: drive RST_IN low mid-run with key 0 stable and repeating → all outputs 0 immediately (asynchronously); after release, BUTTONS_STABLE = 0 until 3 matching samples arrive.
- Clean debounce: BUTTONS_IN = 8'h01 for 3 strobes 10 cycles apart → BUTTONS_STABLE[0] rises, with PRESS_PULSE = 8'h01 for one cycle, the cycle after the 3rd strobe. Then 3 strobes of 8'h00 → RELEASE_PULSE = 8'h01 once.
- Bounce rejection: strobes carrying 1, 1, 0, 1, 1 on key 2 → no press; a 3rd consecutive 1 gives the press. A single glitch 0 while stable-pressed gives no release.
- Repeat timing: hold key 1 (strobe every 5 cycles) → REPEAT_PULSE[1] 20 cycles after PRESS_PULSE, then every 8 cycles. Holding key 5 (masked) gives PRESS_PULSE only, never REPEAT_PULSE.
- Simultaneous: 8'hF0 → 8'h0F transition applied → RELEASE_PULSE = 8'hF0 and PRESS_PULSE = 8'h0F in the same cycle.
- Watchdog: keys 8'h03 stable, strobes stop → STALE high after 100 cycles, RELEASE_PULSE = 8'h03 once, BUTTONS_STABLE = 0. The next strobe clears STALE.
